hilo_muldiv: RTL and testbench
==============================

# hilo_muldiv

Parametrised HI/LO register unit with an iterative multiply/divide engine, serving the EX stage of the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO operations over a valid/ready handshake. Multi-cycle arithmetic results are written to the architectural HI/LO registers on completion. HI/LO are true clocked registers; the old combinational pass-through is replaced.

## Interface
- DW, 32: operand and HI/LO width; must be even and ≥ 8.
- CW, $clog2(DW)+1: iteration counter width (derived; do not override).

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  cancel any in-flight operation (pipeline flush/exception).
- op_valid  in  1  operation request.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved.
- rs_data  in  DW  multiplicand/dividend, or MTHI/MTLO source.
- rt_data  in  DW  multiplier/divisor.
- op_ready  out  1  high when state is IDLE.
- busy  out  1  high in PREP, CALC or DONE.
- done  out  1  registered one-cycle pulse when a MULT/DIV result lands in HI/LO.
- hi_o  out  DW  HI register.
- lo_o  out  DW  LO register.

## Operation
- States: IDLE, PREP, CALC, DONE.
- Accept = op_valid & op_ready & ~flush.
- MTHI/MTLO: write rs_data to HI or LO at the accept edge. No state change, no done.
- Reserved op: accepted and ignored.
- MULT/DIV accept: latch operands and op; IDLE→PREP.
- PREP: signed ops take absolute values and record the result signs; unsigned ops pass through. Count=0; →CALC.
- CALC, multiply: shift-add, one multiplier bit per cycle, 2·DW-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle.
- CALC runs exactly DW cycles, then →DONE.
- DONE: apply sign fixup. Quotient is negative iff operand signs differ; remainder takes the dividend's sign. →IDLE.
- On the DONE→IDLE edge, write HI/LO (mult: HI=upper, LO=lower; div: HI=remainder, LO=quotient) and assert done.
- Divide by zero: HI=rs_data, LO={DW{1}}. Takes the same cycle count.
- Signed overflow (−2^(DW−1) / −1): LO=−2^(DW−1) (wrap), HI=0.
- flush in PREP/CALC/DONE: →IDLE next edge. HI/LO unchanged, no done.
- flush in IDLE blocks acceptance that cycle; MTHI/MTLO are also dropped.
- rst: state IDLE, hi_o=0, lo_o=0, done=0, counter=0. Applies mid-operation; result discarded.

## Timing
- MTHI/MTLO: accepted at edge E0; new value on hi_o/lo_o after E0.
- MULT/DIV: accepted at E0 → PREP → CALC for DW cycles → DONE.
- Result and done appear after edge E0+DW+2; with DW=32, 34 cycles.
- op_ready is low from the cycle after E0 until the cycle done is high. op_ready is high in the done cycle, so back-to-back issue is allowed.
- No HI/LO forwarding: a reader in the same cycle as an MTHI/MTLO write sees the old value.

## Configuration
- HILO_DIV_EN defined: divider datapath and DIV/DIVU behaviour compiled in as above.
- HILO_DIV_EN undefined: no divider logic. DIV/DIVU accept as single-cycle no-ops (HI/LO unchanged, state stays IDLE, no done); multiply unaffected.

## Test plan
- MULT rs=0xFFFFFFFD (−3), rt=5 → after 34 cycles: done=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1.
- MULTU rs=rt=0xFFFFFFFF → hi_o=0xFFFFFFFE, lo_o=0x00000001; op_ready low for cycles 1–33.
- DIV rs=0xFFFFFFF9 (−7), rt=2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU rs=7, rt=0 → hi_o=7, lo_o=0xFFFFFFFF. Without HILO_DIV_EN, both leave HI/LO unchanged with no done.
- MTHI 0x12345678 → hi_o=0x12345678 next cycle. MTLO 0xAA issued during a MULT → not accepted, lo_o gets only the MULT result.
- MULT started, flush at cycle 10 → IDLE next cycle, op_ready=1, no done, hi_o/lo_o hold prior values.
- rst asserted at cycle 20 of a DIV → next cycle hi_o=lo_o=0, busy=0, no done pulse afterwards.

Source files
------------

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: architectural HI/LO registers with an iterative multiply/divide
// engine for the EX stage. MULT/MULTU use shift-add, DIV/DIVU use restoring
// division, one bit per cycle over DW cycles. MTHI/MTLO write HI/LO directly.
// Optional feature macro: HILO_DIV_EN compiles in the divider datapath; when it
// is undefined DIV/DIVU are accepted as single-cycle no-ops.
module hilo_muldiv #(
  parameter int DW = 32,
  parameter int CW = $clog2(DW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          op_valid,
  input  logic [2:0]    op,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  output logic          op_ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          op_reg;        // [1] = divide, [0] = unsigned
  logic [DW-1:0]       rs_reg, rt_reg;
  logic [DW-1:0]       opnd_reg;      // multiplicand or divisor magnitude
  logic [2*DW-1:0]     acc_reg;
  logic [CW-1:0]       cnt_reg;
  logic                neg_q_reg;     // product / quotient must be negated
  logic [DW-1:0]       hi_reg, lo_reg;
  logic                done_reg;

  logic                accept, start;
  logic                rs_neg, rt_neg;
  logic [DW-1:0]       rs_abs, rt_abs;
  logic [DW:0]         mul_sum;
  logic [2*DW-1:0]     mul_next, acc_step;
  logic [2*DW-1:0]     prod_fix;
  logic [DW-1:0]       res_hi, res_lo;

  assign accept = op_valid & op_ready & ~flush;
`ifdef HILO_DIV_EN
  assign start  = accept & (op[2] == 1'b0);
`else
  assign start  = accept & (op[2:1] == 2'b00);
`endif

  // Magnitudes of the latched operands; unsigned ops pass straight through
  assign rs_neg = ~op_reg[0] & rs_reg[DW-1];
  assign rt_neg = ~op_reg[0] & rt_reg[DW-1];
  assign rs_abs = rs_neg ? -rs_reg : rs_reg;
  assign rt_abs = rt_neg ? -rt_reg : rt_reg;

  // Shift-add step: add multiplicand into the upper half when LSB set, shift right
  assign mul_sum  = {1'b0, acc_reg[2*DW-1:DW]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[DW-1:1]};
  assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;

`ifdef HILO_DIV_EN
  logic          neg_r_reg;
  logic [DW:0]   div_trial;
  logic [2*DW-1:0] div_next;
  logic [DW-1:0] quo_fix, rem_fix;

  // Restoring step: shift {rem,quo} left, keep the trial subtraction if non-negative
  assign div_trial = acc_reg[2*DW-1:DW-1] - {1'b0, opnd_reg};
  assign div_next  = div_trial[DW] ? {acc_reg[2*DW-2:0], 1'b0}
                                   : {div_trial[DW-1:0], acc_reg[DW-2:0], 1'b1};
  assign quo_fix   = neg_q_reg ? -acc_reg[DW-1:0]    : acc_reg[DW-1:0];
  assign rem_fix   = neg_r_reg ? -acc_reg[2*DW-1:DW] : acc_reg[2*DW-1:DW];
  assign acc_step  = op_reg[1] ? div_next : mul_next;

  // Final HI/LO selection; divide by zero returns the dividend and all-ones
  always_comb begin
    res_hi = prod_fix[2*DW-1:DW];
    res_lo = prod_fix[DW-1:0];
    if (op_reg[1]) begin
      if (rt_reg == '0) begin
        res_hi = rs_reg;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end
`else
  assign acc_step = mul_next;

  // Final HI/LO selection: only the multiplier exists in this build
  always_comb begin
    res_hi = prod_fix[2*DW-1:DW];
    res_lo = prod_fix[DW-1:0];
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; flush abandons any in-flight operation
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = S_PREP;
      S_PREP: state_next = flush ? S_IDLE : S_CALC;
      S_CALC: if (flush) state_next = S_IDLE;
              else if (cnt_reg == CW'(DW - 1)) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    op_ready = (state_reg == S_IDLE);
    busy     = (state_reg != S_IDLE);
  end

  // Operand latch, sign preparation and iteration datapath
  always_ff @(posedge clk) begin
    if (start) begin
      op_reg <= op[1:0];
      rs_reg <= rs_data;
      rt_reg <= rt_data;
    end
    if (state_reg == S_PREP) begin
      neg_q_reg <= rs_neg ^ rt_neg;
`ifdef HILO_DIV_EN
      neg_r_reg <= rs_neg;
      opnd_reg  <= op_reg[1] ? rt_abs : rs_abs;
      acc_reg   <= {{DW{1'b0}}, (op_reg[1] ? rs_abs : rt_abs)};
`else
      opnd_reg  <= rs_abs;
      acc_reg   <= {{DW{1'b0}}, rt_abs};
`endif
    end else if (state_reg == S_CALC) begin
      acc_reg <= acc_step;
    end
  end

  // Iteration counter
  always_ff @(posedge clk) begin
    if (rst)                         cnt_reg <= '0;
    else if (state_reg == S_PREP)    cnt_reg <= '0;
    else if (state_reg == S_CALC)    cnt_reg <= cnt_reg + 1'b1;
  end

  // Architectural HI/LO plus the registered completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept && op == OP_MTHI) hi_reg <= rs_data;
      if (accept && op == OP_MTLO) lo_reg <= rs_data;
      if (state_reg == S_DONE && !flush) begin
        hi_reg   <= res_hi;
        lo_reg   <= res_lo;
        done_reg <= 1'b1;
      end
    end
  end

  assign hi_o = hi_reg;
  assign lo_o = lo_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed testbench for hilo_muldiv (DW=32). Expectations for DIV/DIVU follow
// the HILO_DIV_EN build option.
module tb_hilo_muldiv;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          op_valid = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [DW-1:0] rs_data = '0;
  logic [DW-1:0] rt_data = '0;
  logic          op_ready, busy, done;
  logic [DW-1:0] hi_o, lo_o;

  int tests_run = 0;
  int tests_failed = 0;

  hilo_muldiv #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .op_ready(op_ready), .busy(busy),
    .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Present one request for exactly one edge; returns #1 after that edge
  task automatic issue(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_valid = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
    $display("[TB] t=%0t op=%0d rs=%h rt=%h", $time, o, a, b);
  endtask

  // Count edges after acceptance until done; -1 if it never arrives
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin n = i; break; end
    end
  endtask

  // Run one arithmetic op and check latency and the HI/LO result
  task automatic run_arith(input string name, input logic [2:0] o, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] ehi, input logic [DW-1:0] elo);
    int n;
    issue(o, a, b);
    wait_done(n);
    tests_run++;
    if (n !== DW + 2) begin tests_failed++; $display("FAIL %s_latency got %0d want %0d", name, n, DW + 2); end
    tests_run++;
    if (hi_o !== ehi) begin tests_failed++; $display("FAIL %s_hi got %h want %h", name, hi_o, ehi); end
    tests_run++;
    if (lo_o !== elo) begin tests_failed++; $display("FAIL %s_lo got %h want %h", name, lo_o, elo); end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL %s_done_pulse got %b want 0", name, done); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({hi_o, lo_o} !== '0) begin tests_failed++; $display("FAIL reset_hilo got %h/%h want 0/0", hi_o, lo_o); end
    tests_run++;
    if ({op_ready, busy, done} !== 3'b100) begin tests_failed++; $display("FAIL reset_ctl got %b want 100", {op_ready, busy, done}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mthi_mtlo;
    op_valid = 1'b1; op = 3'd4; rs_data = 32'h12345678;
    tests_run++;
    if (hi_o !== 32'h0) begin tests_failed++; $display("FAIL mthi_no_forward got %h want 0", hi_o); end
    @(posedge clk); #1;
    op_valid = 1'b0;
    $display("[TB] t=%0t MTHI %h", $time, rs_data);
    tests_run++;
    if (hi_o !== 32'h12345678) begin tests_failed++; $display("FAIL mthi got %h want 12345678", hi_o); end
    issue(3'd5, 32'h0BADF00D, 32'h0);
    tests_run++;
    if (lo_o !== 32'h0BADF00D || hi_o !== 32'h12345678) begin
      tests_failed++; $display("FAIL mtlo got %h/%h want 12345678/0badf00d", hi_o, lo_o);
    end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL mt_busy got %b want 0", busy); end
  endtask

  task automatic test_mult;
    run_arith("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_arith("mult_negneg", 3'd0, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0, 32'h6);
  endtask

  // MULTU with op_ready watched every cycle and an MTLO attempted mid-operation
  task automatic test_multu_ready;
    int bad_ready = 0;
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 1; i <= DW + 2; i++) begin
      if (i == 5) begin op_valid = 1'b1; op = 3'd5; rs_data = 32'hAA; end
      @(posedge clk); #1;
      if (i == 5) op_valid = 1'b0;
      if (i <= DW + 1 && op_ready !== 1'b0) bad_ready++;
    end
    tests_run++;
    if (bad_ready != 0) begin tests_failed++; $display("FAIL multu_ready_low got %0d high cycles want 0", bad_ready); end
    tests_run++;
    if (done !== 1'b1 || op_ready !== 1'b1) begin tests_failed++; $display("FAIL multu_done got done=%b ready=%b want 1/1", done, op_ready); end
    tests_run++;
    if (hi_o !== 32'hFFFFFFFE || lo_o !== 32'h00000001) begin
      tests_failed++; $display("FAIL multu_result got %h/%h want fffffffe/00000001", hi_o, lo_o);
    end
  endtask

  task automatic test_div;
`ifdef HILO_DIV_EN
    run_arith("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_arith("div_negdivisor", 3'd2, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);
    run_arith("divu_zero", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
    run_arith("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_arith("divu_big", 3'd3, 32'hFFFFFFFF, 32'd16, 32'hF, 32'h0FFFFFFF);
`else
    int seen = 0;
    issue(3'd4, 32'hCAFE, 32'h0);
    issue(3'd5, 32'hBEEF, 32'h0);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    tests_run++;
    if (op_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL nodiv_idle got ready=%b busy=%b want 1/0", op_ready, busy); end
    issue(3'd3, 32'd7, 32'd0);
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) seen++; end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL nodiv_done got %0d pulses want 0", seen); end
    tests_run++;
    if (hi_o !== 32'hCAFE || lo_o !== 32'hBEEF) begin tests_failed++; $display("FAIL nodiv_hilo got %h/%h want cafe/beef", hi_o, lo_o); end
`endif
  endtask

  task automatic test_flush;
    int seen = 0;
    issue(3'd4, 32'h11, 32'h0);
    issue(3'd5, 32'h22, 32'h0);
    issue(3'd0, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests_run++;
    if (op_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL flush_idle got ready=%b busy=%b want 1/0", op_ready, busy); end
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) seen++; end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL flush_done got %0d pulses want 0", seen); end
    tests_run++;
    if (hi_o !== 32'h11 || lo_o !== 32'h22) begin tests_failed++; $display("FAIL flush_hilo got %h/%h want 11/22", hi_o, lo_o); end
    flush = 1'b1;
    issue(3'd4, 32'h99, 32'h0);
    flush = 1'b0;
    tests_run++;
    if (hi_o !== 32'h11) begin tests_failed++; $display("FAIL flush_blocks_mthi got %h want 11", hi_o); end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
`ifdef HILO_DIV_EN
    issue(3'd2, 32'd1000, 32'd3);
`else
    issue(3'd0, 32'd1000, 32'd3);
`endif
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid got %h/%h busy=%b want 0/0 busy=0", hi_o, lo_o, busy);
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) seen++; end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL rst_mid_done got %0d pulses want 0", seen); end
  endtask

  // Issue the second operation in the very cycle the first one completes
  task automatic test_back_to_back;
    int n;
    issue(3'd1, 32'd9, 32'd9);
    wait_done(n);
    tests_run++;
    if (n !== DW + 2 || lo_o !== 32'd81) begin tests_failed++; $display("FAIL b2b_first got n=%0d lo=%h want %0d/51", n, lo_o, DW + 2); end
    issue(3'd1, 32'd6, 32'd7);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
    wait_done(n);
    tests_run++;
    if (n !== DW + 2 || hi_o !== 32'h0 || lo_o !== 32'd42) begin
      tests_failed++; $display("FAIL b2b_second got n=%0d %h/%h want %0d 0/2a", n, hi_o, lo_o, DW + 2);
    end
  endtask

  initial begin
    test_reset;
    test_mthi_mtlo;
    test_mult;
    test_multu_ready;
    test_div;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
